// File: rtl/jedro_1_ifu_pkg.sv
// rtl/jedro_1_ifu_pkg.sv - shared types and constants for the jedro_1 fetch unit
// Purpose: fetch-entry type {instr, pc}, PC step, and the storage reset entry (NOP at PC 0).
package jedro_1_ifu_pkg;

    localparam int XLEN       = 32;
    localparam int INSTR_STEP = 4;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] RESET_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    localparam fetch_entry_t RESET_ENTRY = '{instr: RESET_INSTR, pc: '0};

endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// rtl/jedro_1_ifu_fifo.sv - synchronous prefetch FIFO with flush
// Purpose: DEPTH-entry FIFO of entry_t; head is read combinationally from storage.
// Ports: clk_i, rst_i (sync, active high), flush_i (drops all entries),
//        push_i/wdata_i, pop_i, rdata_o (head), full_o, empty_o, count_o.
module jedro_1_ifu_fifo #(
    parameter int  DEPTH = 4,
    parameter type entry_t = logic [63:0],
    parameter entry_t RESET_ENTRY = '0,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  entry_t           wdata_i,
    input  logic             pop_i,
    output entry_t           rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = wdata_i;
                wptr_d        = wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_ENTRY;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/jedro_1_ifu.sv
// rtl/jedro_1_ifu.sv - jedro_1 instruction fetch unit
// Purpose: sequential word fetch from a 1-cycle ROM into a prefetch FIFO, valid/ready
//          hand-off to the decoder, flush and redirect on jmp_i.
// Ports: clk_i, rst_i (sync, active high); mem_addr_o/mem_en_o/mem_rdata_i (ROM);
//        jmp_i/jmp_addr_i (redirect); instr_o/pc_o/valid_o/ready_i (decoder);
//        misaligned_o only when JEDRO_1_IFU_MISALIGN_CHECK_EN is defined.
module jedro_1_ifu
    import jedro_1_ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_en_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  jmp_i,
    input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  valid_o,
    input  logic                  ready_i
`ifdef JEDRO_1_IFU_MISALIGN_CHECK_EN
    ,
    output logic                  misaligned_o
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] issued_pc_q, issued_pc_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] instr_hold_q, instr_hold_d;
    logic [ADDR_WIDTH-1:0] pc_hold_q, pc_hold_d;

    fetch_entry_t          push_entry, head_entry;
    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      occupancy;
    logic                  issue, push, pop, stall;

`ifdef JEDRO_1_IFU_MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;

    always_comb begin
        misaligned_d = misaligned_q;
        if (jmp_i) begin
            misaligned_d = |jmp_addr_i[1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign stall        = misaligned_q;
    assign misaligned_o = misaligned_q;
`else
    assign stall = 1'b0;
`endif

    // Slots already promised: buffered entries plus the read still coming back.
    assign occupancy = fifo_count + CNT_W'(inflight_q);
    assign issue     = !rst_i && !jmp_i && !stall && (occupancy < CNT_W'(FIFO_DEPTH));

    assign mem_en_o   = issue;
    assign mem_addr_o = fetch_pc_q;

    // A return landing in a jump cycle belongs to the old stream and is dropped.
    assign push             = inflight_q && !jmp_i;
    assign push_entry.instr = mem_rdata_i;
    assign push_entry.pc    = issued_pc_q;

    assign valid_o = !fifo_empty && !stall;
    assign pop     = valid_o && ready_i && !jmp_i;

    // While empty, show what was shown last cycle rather than stale storage.
    assign instr_o = fifo_empty ? instr_hold_q : head_entry.instr;
    assign pc_o    = fifo_empty ? pc_hold_q : head_entry.pc;

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        issued_pc_d  = issued_pc_q;
        inflight_d   = issue;
        instr_hold_d = instr_o;
        pc_hold_d    = pc_o;
        if (jmp_i) begin
            fetch_pc_d = {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (issue) begin
            fetch_pc_d  = fetch_pc_q + ADDR_WIDTH'(INSTR_STEP);
            issued_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q   <= BOOT_ADDR;
            issued_pc_q  <= BOOT_ADDR;
            inflight_q   <= 1'b0;
            instr_hold_q <= '0;
            pc_hold_q    <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            issued_pc_q  <= issued_pc_d;
            inflight_q   <= inflight_d;
            instr_hold_q <= instr_hold_d;
            pc_hold_q    <= pc_hold_d;
        end
    end

    jedro_1_ifu_fifo #(
        .DEPTH       (FIFO_DEPTH),
        .entry_t     (fetch_entry_t),
        .RESET_ENTRY (RESET_ENTRY)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (jmp_i),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: doc/jedro_1_ifu.md
Name: jedro_1_ifu

Overview:
Instruction fetch unit for the jedro_1 core. It sits between the instruction ROM (synchronous, 1-cycle read latency) and the decoder. It issues sequential word fetches and buffers returned instructions, with their PCs, in a small prefetch FIFO. It hands them to the decoder over a valid/ready handshake and flushes and redirects on jumps or branches from the execute stage.

Parameters:
ADDR_WIDTH, 32, width of instruction address and PC
DATA_WIDTH, 32, instruction word width
BOOT_ADDR, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, prefetch entries; power of two, at least 2

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mem_addr_o  out  ADDR_WIDTH  ROM byte address, always word-aligned
mem_en_o  out  1  ROM read enable; data on mem_rdata_i the next cycle
mem_rdata_i  in  DATA_WIDTH  ROM read data
jmp_i  in  1  redirect request (jump, branch taken, trap)
jmp_addr_i  in  ADDR_WIDTH  redirect target
instr_o  out  DATA_WIDTH  instruction at FIFO head
pc_o  out  ADDR_WIDTH  PC of instr_o
valid_o  out  1  FIFO head valid
ready_i  in  1  decoder accepts head this cycle
misaligned_o  out  1  present only with the optional feature

Behaviour:
- Reset (rst_i high at a clock edge): FIFO empty, in-flight flag 0, fetch_pc = BOOT_ADDR. Outputs: valid_o=0, mem_en_o=0, mem_addr_o=BOOT_ADDR, instr_o=0, pc_o=0, misaligned_o=0. Reset has priority over every other input. A read in flight when reset arrives is discarded.
- Issue rule: mem_en_o=1 when not in reset, jmp_i=0, and (count + inflight) < FIFO_DEPTH. mem_addr_o=fetch_pc. On issue, fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH). Inflight is set, and the issued PC is latched.
- Return: the cycle after an issue, if the read was not discarded, {mem_rdata_i, latched PC} is pushed. valid_o rises on the following cycle because the FIFO output is registered from storage.
- Latency: first mem_en_o in the first cycle after reset deasserts. With ready_i held high, valid_o=1 two cycles later. Steady-state throughput is 1 instruction/cycle.
- Pop: when valid_o && ready_i, the head is removed. Simultaneous push and pop in the same cycle is legal at any count, including full.
- Full: no new issue while count + inflight == FIFO_DEPTH. Data is never dropped.
- Empty: valid_o=0. instr_o and pc_o hold their last values; their contents are don't-care.
- Jump (jmp_i=1): same edge, FIFO cleared and any in-flight return marked discarded. fetch_pc = {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00}. No issue in the jump cycle; the first redirected fetch issues the next cycle. A pop in the jump cycle is ignored, and valid_o is 0 the cycle after the jump. Jump has priority over push, pop and issue.
- Back-to-back jumps: the last one wins. Each jump discards everything from before it.
- Pointers: log2(FIFO_DEPTH)-bit read/write pointers wrap naturally. count is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
JEDRO_1_IFU_MISALIGN_CHECK_EN
- Defined: the misaligned_o port exists. misaligned_o is registered: it goes to 1 the cycle after a jump with jmp_addr_i[1:0] != 0, and it clears on reset or on the next aligned jump. While it is 1, fetching stalls (mem_en_o=0) and valid_o=0, so the core can raise an instruction-address-misaligned trap.
- Not defined: no misaligned_o port. The low two bits of jmp_addr_i are silently cleared.

Decomposition:
- Package jedro_1_ifu_pkg holds:
  - the fetch-entry typedef {instr, pc}
  - the INSTR_STEP=4 constant
  - the RESET instruction constant 32'h0000_0013 (NOP), used to initialise storage
- One sub-module, jedro_1_ifu_fifo: a synchronous FIFO with a flush input, push, pop, full, empty and count, parameterised by depth and entry type.

Test Plan:
- Reset then free-run, ROM holding addi x1..x5 at 0x0–0x10, ready_i=1 -> pc_o sequence 0x0,0x4,0x8,0xC,0x10 on consecutive cycles; first valid_o exactly 2 cycles after first mem_en_o.
- ready_i=0 for 10 cycles after reset -> exactly FIFO_DEPTH=4 issues (0x0–0xC), mem_en_o=0 afterwards. Release ready_i -> 0x0,0x4,0x8,0xC delivered in order, fetch resumes at 0x10.
- jmp_i with jmp_addr_i=0x40 while the FIFO holds 3 entries and a read is in flight -> valid_o=0 the next cycle, next mem_addr_o=0x40, next delivered pc_o=0x40. No pre-jump instruction ever appears.
- jmp_i on two consecutive cycles (0x80, then 0x100) -> first delivered pc_o=0x100; 0x80 is never delivered.
- rst_i asserted mid-stream with 2 entries buffered -> valid_o=0 and mem_addr_o=BOOT_ADDR the next cycle; first delivered pc_o=0x0.
- JEDRO_1_IFU_MISALIGN_CHECK_EN defined, jump to 0x42 -> misaligned_o=1 next cycle, no fetches. A following jump to 0x44 clears misaligned_o and delivers pc_o=0x44.
